// File: rtl/l1mmu_arbiter.sv
// l1mmu_arbiter: shares the single l1mmu port between the icache fetch path
// and the dcache. One transaction is granted at a time and held until
// mmu_done. Contested grants alternate round-robin. A saturating watchdog
// raises a sticky error when a grant never completes.
module l1mmu_arbiter #(
    parameter int LINE_W = 256,
    parameter int TO_W   = 10
) (
    input  logic              sys_clk,
    input  logic              rst_n,

    // icache side (read-only)
    input  logic              ic_read,
    input  logic [31:0]       ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_read_data,

    // dcache side (line read / writeback)
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [31:0]       dc_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_read_data,

    // l1mmu side
    output logic              mmu_read,
    output logic              mmu_write,
    output logic [31:0]       mmu_addr,
    output logic [LINE_W-1:0] mmu_write_data,
    input  logic              mmu_done,
    input  logic [LINE_W-1:0] mmu_read_data,

    // status
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    // Encoding of the side served most recently.
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    localparam logic [TO_W-1:0] WD_MAX = '1;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              mmu_read_q, mmu_read_d;
    logic              mmu_write_q, mmu_write_d;
    logic [31:0]       mmu_addr_q, mmu_addr_d;
    logic [LINE_W-1:0] mmu_write_data_q, mmu_write_data_d;
    logic              busy_q, busy_d;
    logic              err_timeout_q, err_timeout_d;
    logic [TO_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic              ic_req;
    logic              dc_req;
    logic              pick_i;
    logic              pick_d;

    // Request evaluation in IDLE: a lone requester wins; when both ask,
    // the side that was not served last wins.
    always_comb begin
        ic_req = ic_read;
        dc_req = dc_read | dc_write;
        pick_i = ic_req & (~dc_req | (last_q == SIDE_D));
        pick_d = dc_req & ~pick_i;
    end

    // Next-state, l1mmu request latching, watchdog and sticky error.
    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        mmu_read_d       = mmu_read_q;
        mmu_write_d      = mmu_write_q;
        mmu_addr_d       = mmu_addr_q;
        mmu_write_data_d = mmu_write_data_q;
        wd_cnt_d         = wd_cnt_q;
        err_timeout_d    = err_timeout_q;

        case (state_q)
            IDLE: begin
                // mmu_done is ignored here; only requests are looked at.
                if (pick_i) begin
                    state_d     = GNT_I;
                    mmu_read_d  = 1'b1;
                    mmu_write_d = 1'b0;
                    mmu_addr_d  = ic_addr;
                    wd_cnt_d    = '0;
                end else if (pick_d) begin
                    // Read and write together is illegal; the write wins.
                    state_d          = GNT_D;
                    mmu_write_d      = dc_write;
                    mmu_read_d       = dc_read & ~dc_write;
                    mmu_addr_d       = dc_addr;
                    mmu_write_data_d = dc_write_data;
                    wd_cnt_d         = '0;
                end
            end

            GNT_I, GNT_D: begin
                // Requester inputs are ignored while a grant is open, so the
                // latched mmu_* values stay stable until completion.
                wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : (wd_cnt_q + 1'b1);
                if (wd_cnt_d == WD_MAX) begin
                    err_timeout_d = 1'b1;
                end
                if (mmu_done) begin
                    state_d     = IDLE;
                    mmu_read_d  = 1'b0;
                    mmu_write_d = 1'b0;
                    last_d      = (state_q == GNT_I) ? SIDE_I : SIDE_D;
                end
            end

            default: begin
                state_d     = IDLE;
                mmu_read_d  = 1'b0;
                mmu_write_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight request at once.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            last_q           <= SIDE_D;
            mmu_read_q       <= 1'b0;
            mmu_write_q      <= 1'b0;
            mmu_addr_q       <= '0;
            mmu_write_data_q <= '0;
            busy_q           <= 1'b0;
            err_timeout_q    <= 1'b0;
            wd_cnt_q         <= '0;
        end else begin
            state_q          <= state_d;
            last_q           <= last_d;
            mmu_read_q       <= mmu_read_d;
            mmu_write_q      <= mmu_write_d;
            mmu_addr_q       <= mmu_addr_d;
            mmu_write_data_q <= mmu_write_data_d;
            busy_q           <= busy_d;
            err_timeout_q    <= err_timeout_d;
            wd_cnt_q         <= wd_cnt_d;
        end
    end

    // Completion is forwarded combinationally only to the side holding the grant.
    always_comb begin
        ic_done      = (state_q == GNT_I) & mmu_done;
        dc_done      = (state_q == GNT_D) & mmu_done;
        ic_read_data = mmu_read_data;
        dc_read_data = mmu_read_data;
    end

    assign mmu_read       = mmu_read_q;
    assign mmu_write      = mmu_write_q;
    assign mmu_addr       = mmu_addr_q;
    assign mmu_write_data = mmu_write_data_q;
    assign busy           = busy_q;
    assign err_timeout    = err_timeout_q;

endmodule
